fpga_ram_req_ctrl: RTL and testbench
====================================

Name: fpga_ram_req_ctrl

Overview:
Requester-side controller that owns the single port of the team's write-first single-port FPGA RAM. Accepts valid/ready read/write requests and drives the RAM address/data/write-enable. Captures the RAM's registered read data one cycle later and returns it on a valid/ready response channel through a 2-entry buffer. After reset it sweeps the whole array with INIT_VALUE before taking requests.

Parameters:
DATAWIDTH, 32, RAM word width.
ADDRWIDTH, 10, RAM address width; MEMDEPTH = 2**ADDRWIDTH.
INIT_EN, 1, 1 = zero-fill sweep after reset; 0 = skip the sweep.
INIT_VALUE, 0, word written to every address during the sweep.

Ports:
forever_cpuclk  in  1  clock; also drives the RAM clock.
cpurst_b  in  1  asynchronous active-low reset.
req_vld  in  1  request valid.
req_rdy  out  1  request ready.
req_wen  in  1  1 = write, 0 = read.
req_addr  in  ADDRWIDTH  request address.
req_wdata  in  DATAWIDTH  write data.
rsp_vld  out  1  read response valid.
rsp_rdy  in  1  response ready.
rsp_rdata  out  DATAWIDTH  read data.
init_done  out  1  sweep complete; level signal.
ram_addr  out  ADDRWIDTH  to RAM address.
ram_din  out  DATAWIDTH  to RAM data in.
ram_wen  out  1  to RAM write enable.
ram_dout  in  DATAWIDTH  from RAM registered data out.

Behaviour:
- One clock; reset is asynchronous, active-low (cpurst_b); all flops clear on assertion.
- FSM states: RST_WAIT, INIT, RUN.
  - Reset state is RST_WAIT.
  - RST_WAIT -> INIT after 1 cycle if INIT_EN = 1, otherwise -> RUN.
  - INIT -> RUN after the write to address MEMDEPTH-1.
  - RUN is held until reset.
- RST_WAIT: ram_wen = 0, req_rdy = 0.
- INIT:
  - ram_wen = 1, ram_addr = sweep counter, ram_din = INIT_VALUE.
  - Counter starts at 0 and increments by 1 per cycle (ADDRWIDTH bits, no wrap used).
  - Sweep takes exactly MEMDEPTH cycles; req_rdy = 0 throughout.
- init_done = 1 in RUN only. Reset value is 0.
- RUN datapath:
  - ram_addr = req_addr and ram_din = req_wdata, combinational.
  - ram_wen = req_vld & req_rdy & req_wen.
  - Idle cycles perform a harmless RAM read of req_addr.
- Writes are accepted with no response. The RAM's write-first output is ignored.
- Reads:
  - Accepted read sets rd_inflight = 1 for the next cycle.
  - In that cycle ram_dout is pushed into the response FIFO.
  - Latency from read accept to earliest rsp_vld is 2 cycles.
- Response FIFO:
  - 2 entries, in-order.
  - rsp_vld = FIFO not empty; rsp_rdata = head entry.
  - Pop on rsp_vld & rsp_rdy.
- Credit rule: req_rdy = RUN & ((fifo_cnt + rd_inflight < 2) | pop).
  - This is a combinational path from rsp_rdy to req_rdy.
  - The FIFO can never overflow.
  - Sustained 1 read/cycle when rsp_rdy is held at 1.
- Simultaneous push and pop is legal and leaves the count unchanged. Push while full is impossible by construction; assert it in sim.
- Read-after-write to the same address in consecutive cycles returns the new data (RAM write completes before the read).
- Reset mid-operation drops the in-flight read and FIFO contents. rsp_vld returns to 0 and the sweep restarts from address 0.
- Reset values: req_rdy 0, rsp_vld 0, rsp_rdata 0, init_done 0, ram_wen 0, ram_addr 0, ram_din 0.

Decomposition:
- Shared package: FSM state encoding (2-bit constants for RST_WAIT/INIT/RUN) and the response FIFO depth constant (2).
- One sub-module: fpga_ram_rsp_fifo, a 2-entry valid/ready FIFO parameterised by DATAWIDTH. It exposes push, pop, count, empty and full.
- FSM, sweep counter, credit logic and RAM muxing stay in the top level.

Test Plan:
- Init sweep (ADDRWIDTH=3, INIT_VALUE=0xA5) -> exactly 8 consecutive RAM writes to addresses 0..7 with din 0xA5. init_done rises 9 cycles after reset release. Reading addresses 0..7 then returns 0xA5.
- Write addr 5 = 0x1234_5678, read addr 5 the next cycle -> rsp_vld 2 cycles after the read accept, rsp_rdata 0x1234_5678, no response for the write.
- Back-to-back reads of addresses 0..7 with rsp_rdy=1 -> req_rdy stays 1 and 8 responses arrive on consecutive cycles in address order.
- rsp_rdy=0 with continuous read requests -> 2 reads accepted, then req_rdy=0. One rsp_rdy pulse -> 1 response popped and 1 new read accepted in the same cycle.
- cpurst_b asserted mid-sweep at counter 4 -> outputs return to reset values immediately. After release the sweep restarts at address 0 and runs the full 8 cycles.
- INIT_EN=0 -> init_done=1 one cycle after reset release, with no RAM writes issued.

Source files
------------

// File: rtl/fpga_ram_req_ctrl_pkg.sv
// Shared definitions for the FPGA RAM requester controller and its response FIFO.
package fpga_ram_req_ctrl_pkg;

  // Controller phases: wait one cycle after reset, optionally sweep the array, then serve requests.
  typedef enum logic [1:0] {
    RST_WAIT = 2'd0,
    INIT     = 2'd1,
    RUN      = 2'd2
  } ctrl_state_e;

  // The response buffer holds at most this many read results.
  localparam int unsigned RSP_FIFO_DEPTH = 2;

  // Width needed to count 0..RSP_FIFO_DEPTH entries.
  localparam int unsigned RSP_CNT_W = $clog2(RSP_FIFO_DEPTH + 1);

endpackage

// File: rtl/fpga_ram_rsp_fifo.sv
// Two-entry in-order FIFO that buffers read data between the RAM and the response channel.
module fpga_ram_rsp_fifo
  import fpga_ram_req_ctrl_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 push_i,
  input  logic [DATAWIDTH-1:0] push_data_i,
  input  logic                 pop_i,
  output logic [DATAWIDTH-1:0] head_data_o,
  output logic [RSP_CNT_W-1:0] count_o,
  output logic                 empty_o,
  output logic                 full_o
);

  logic [DATAWIDTH-1:0] entryQ [RSP_FIFO_DEPTH];
  logic                 wrPtrQ;
  logic                 rdPtrQ;
  logic [RSP_CNT_W-1:0] countQ;
  logic [RSP_CNT_W-1:0] countD;

  // Occupancy moves only when exactly one of push/pop happens; both together cancel out.
  always_comb begin
    countD = countQ;
    case ({push_i, pop_i})
      2'b10:   countD = countQ + RSP_CNT_W'(1);
      2'b01:   countD = countQ - RSP_CNT_W'(1);
      default: countD = countQ;
    endcase
  end

  // Storage and pointers; the one-bit pointers toggle between the two slots.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      entryQ <= '{default: '0};
      wrPtrQ <= 1'b0;
      rdPtrQ <= 1'b0;
      countQ <= '0;
    end else begin
      if (push_i) begin
        entryQ[wrPtrQ] <= push_data_i;
      end
      wrPtrQ <= wrPtrQ ^ push_i;
      rdPtrQ <= rdPtrQ ^ pop_i;
      countQ <= countD;
    end
  end

  assign head_data_o = entryQ[rdPtrQ];
  assign count_o     = countQ;
  assign empty_o     = (countQ == '0);
  assign full_o      = (countQ == RSP_CNT_W'(RSP_FIFO_DEPTH));

endmodule

// File: rtl/fpga_ram_req_ctrl.sv
// Owns the single port of a write-first FPGA RAM: optional init sweep after reset,
// then valid/ready read/write requests with buffered read responses.
module fpga_ram_req_ctrl
  import fpga_ram_req_ctrl_pkg::*;
#(
  parameter int unsigned          DATAWIDTH  = 32,
  parameter int unsigned          ADDRWIDTH  = 10,
  parameter bit                   INIT_EN    = 1'b1,
  parameter logic [DATAWIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst_b,
  input  logic                 req_vld,
  output logic                 req_rdy,
  input  logic                 req_wen,
  input  logic [ADDRWIDTH-1:0] req_addr,
  input  logic [DATAWIDTH-1:0] req_wdata,
  output logic                 rsp_vld,
  input  logic                 rsp_rdy,
  output logic [DATAWIDTH-1:0] rsp_rdata,
  output logic                 init_done,
  output logic [ADDRWIDTH-1:0] ram_addr,
  output logic [DATAWIDTH-1:0] ram_din,
  output logic                 ram_wen,
  input  logic [DATAWIDTH-1:0] ram_dout
);

  localparam int unsigned          MEMDEPTH  = 2 ** ADDRWIDTH;
  localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(MEMDEPTH - 1);

  ctrl_state_e          stateQ;
  ctrl_state_e          stateD;
  logic [ADDRWIDTH-1:0] sweepCntQ;
  logic [ADDRWIDTH-1:0] sweepCntD;
  logic                 rdInflightQ;

  logic                 fifoEmpty;
  logic                 fifoFull;
  logic [RSP_CNT_W-1:0] fifoCnt;
  logic [2:0]           outstanding;
  logic                 rspPop;
  logic                 reqAccept;
  logic                 rdAccept;

  // Read credit: FIFO entries plus the read still coming out of the RAM must leave room,
  // or a pop this cycle frees one slot (so rsp_rdy feeds req_rdy combinationally).
  assign outstanding = {1'b0, fifoCnt} + {2'b00, rdInflightQ};
  assign rspPop      = rsp_vld & rsp_rdy;
  assign req_rdy     = (stateQ == RUN) & ((outstanding < 3'(RSP_FIFO_DEPTH)) | rspPop);
  assign reqAccept   = req_vld & req_rdy;
  assign rdAccept    = reqAccept & ~req_wen;
  assign init_done   = (stateQ == RUN);

  // Phase sequencing: the sweep counter walks every address once, then RUN is held until reset.
  always_comb begin
    stateD    = stateQ;
    sweepCntD = sweepCntQ;
    case (stateQ)
      RST_WAIT: begin
        sweepCntD = '0;
        stateD    = INIT_EN ? INIT : RUN;
      end
      INIT: begin
        sweepCntD = sweepCntQ + ADDRWIDTH'(1);
        if (sweepCntQ == LAST_ADDR) begin
          stateD = RUN;
        end
      end
      RUN:     stateD = RUN;
      default: stateD = RST_WAIT;
    endcase
  end

  // RAM port mux: sweep writes during INIT, pass-through of the request in RUN; idle RUN cycles read harmlessly.
  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    ram_wen  = 1'b0;
    case (stateQ)
      INIT: begin
        ram_addr = sweepCntQ;
        ram_din  = INIT_VALUE;
        ram_wen  = 1'b1;
      end
      RUN: begin
        ram_addr = req_addr;
        ram_din  = req_wdata;
        ram_wen  = reqAccept & req_wen;
      end
      default: begin
        ram_addr = '0;
        ram_din  = '0;
        ram_wen  = 1'b0;
      end
    endcase
  end

  // Control registers; rdInflight marks the cycle in which ram_dout holds the accepted read's data.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      stateQ      <= RST_WAIT;
      sweepCntQ   <= '0;
      rdInflightQ <= 1'b0;
    end else begin
      stateQ      <= stateD;
      sweepCntQ   <= sweepCntD;
      rdInflightQ <= rdAccept;
    end
  end

  fpga_ram_rsp_fifo #(
    .DATAWIDTH (DATAWIDTH)
  ) u_rsp_fifo (
    .clk_i       (forever_cpuclk),
    .rst_n_i     (cpurst_b),
    .push_i      (rdInflightQ),
    .push_data_i (ram_dout),
    .pop_i       (rspPop),
    .head_data_o (rsp_rdata),
    .count_o     (fifoCnt),
    .empty_o     (fifoEmpty),
    .full_o      (fifoFull)
  );

  assign rsp_vld = ~fifoEmpty;

  // The credit rule must make a push into a full buffer unreachable.
  noPushWhenFull : assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
                                    !(rdInflightQ && fifoFull));

endmodule

// File: tb/tb_fpga_ram_req_ctrl.sv
// Scoreboard bench for fpga_ram_req_ctrl with a small write-first RAM model.
module tb_fpga_ram_req_ctrl;

  localparam int unsigned     DW    = 32;
  localparam int unsigned     AW    = 3;
  localparam int unsigned     DEPTH = 8;
  localparam logic [DW-1:0]   INITV = 32'h0000_00A5;

  logic          clk = 1'b0;
  logic          rstB = 1'b0;
  logic          reqVld = 1'b0, reqWen = 1'b0, rspRdy = 1'b0;
  logic [AW-1:0] reqAddr = '0;
  logic [DW-1:0] reqWdata = '0;
  logic          reqRdy, rspVld, initDone, ramWen;
  logic [DW-1:0] rspRdata, ramDin, ramDout;
  logic [AW-1:0] ramAddr;

  logic          reqVld2 = 1'b0, reqWen2 = 1'b0, rspRdy2 = 1'b0;
  logic [AW-1:0] reqAddr2 = '0;
  logic [DW-1:0] reqWdata2 = '0, ramDout2 = '0;
  logic          reqRdy2, rspVld2, initDone2, ramWen2;
  logic [DW-1:0] rspRdata2, ramDin2;
  logic [AW-1:0] ramAddr2;
  logic          sawWen2 = 1'b0;

  logic [DW-1:0] ramMem [DEPTH];
  logic [DW-1:0] refMem [DEPTH];
  logic [DW-1:0] expQ [$];
  int            checks = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  fpga_ram_req_ctrl #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .INIT_EN(1'b1), .INIT_VALUE(INITV)) dut (
    .forever_cpuclk(clk), .cpurst_b(rstB), .req_vld(reqVld), .req_rdy(reqRdy), .req_wen(reqWen),
    .req_addr(reqAddr), .req_wdata(reqWdata), .rsp_vld(rspVld), .rsp_rdy(rspRdy),
    .rsp_rdata(rspRdata), .init_done(initDone), .ram_addr(ramAddr), .ram_din(ramDin),
    .ram_wen(ramWen), .ram_dout(ramDout));

  fpga_ram_req_ctrl #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .INIT_EN(1'b0), .INIT_VALUE(INITV)) dut2 (
    .forever_cpuclk(clk), .cpurst_b(rstB), .req_vld(reqVld2), .req_rdy(reqRdy2), .req_wen(reqWen2),
    .req_addr(reqAddr2), .req_wdata(reqWdata2), .rsp_vld(rspVld2), .rsp_rdy(rspRdy2),
    .rsp_rdata(rspRdata2), .init_done(initDone2), .ram_addr(ramAddr2), .ram_din(ramDin2),
    .ram_wen(ramWen2), .ram_dout(ramDout2));

  // Write-first single-port RAM with registered output.
  always @(posedge clk) begin
    if (ramWen) ramMem[ramAddr] <= ramDin;
    ramDout <= ramWen ? ramDin : ramMem[ramAddr];
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: accepted reads push the reference word; handshaken responses pop and compare.
  always @(negedge clk) begin
    if (rstB) begin
      if (reqVld && reqRdy && !reqWen) expQ.push_back(refMem[reqAddr]);
      if (reqVld && reqRdy && reqWen)  refMem[reqAddr] = reqWdata;
      if (rspVld && rspRdy) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL rsp_unexpected: got response 0x%0h with no read outstanding", rspRdata);
        end else begin
          checkOutput("rsp_data", rspRdata, expQ.pop_front());
        end
      end
    end
    if (ramWen2) sawWen2 = 1'b1;
  end

  // Instance without sweep: RUN one cycle after the first reset release.
  initial begin
    @(posedge rstB);
    @(negedge clk);
    checkOutput("noinit_done_c0", initDone2, 0);
    @(negedge clk);
    checkOutput("noinit_done_c1", initDone2, 1);
  end

  task automatic applyStimulus(input logic vld, input logic wen, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data);
    reqVld = vld; reqWen = wen; reqAddr = addr; reqWdata = data;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sendReq(input logic wen, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bit done = 1'b0;
    applyStimulus(1'b1, wen, addr, data);
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (reqRdy) done = 1'b1;
      nextCycle();
    end
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL req_timeout: got req_rdy low for 50 cycles expected accept, addr %0d", addr);
    end
  endtask

  task automatic sweepCheck(input string tag);
    @(negedge clk);
    checkOutput({tag, "_rstwait"}, {ramWen, reqRdy, initDone}, 3'b000);
    for (int i = 0; i < int'(DEPTH); i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, "_write"}, {ramWen, reqRdy, initDone, ramAddr, ramDin},
                  {1'b1, 1'b0, 1'b0, AW'(i), INITV});
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_done"}, {initDone, ramWen}, 2'b10);
    for (int i = 0; i < int'(DEPTH); i++) refMem[i] = INITV;
    nextCycle();
  endtask

  task automatic backToBackReads(input string tag);
    rspRdy = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (k < 8) applyStimulus(1'b1, 1'b0, AW'(k), '0);
      else       applyStimulus(1'b0, 1'b0, '0, '0);
      @(negedge clk);
      if (k < 8) checkOutput({tag, "_rdy"}, reqRdy, 1);
      checkOutput({tag, "_rspvld"}, rspVld, (k >= 2 && k < 10));
      nextCycle();
    end
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) refMem[i] = INITV;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs", {reqRdy, rspVld, rspRdata, initDone, ramWen, ramAddr, ramDin}, '0);
    checkOutput("reset_outputs2", {reqRdy2, rspVld2, rspRdata2, initDone2, ramWen2, ramAddr2, ramDin2}, '0);

    // Full sweep, then readback of the initial value.
    nextCycle();
    rstB = 1'b1;
    sweepCheck("sweep1");
    backToBackReads("readA5");

    // Write then read the same address on the next cycle.
    sendReq(1'b1, 3'd5, 32'h1234_5678);
    sendReq(1'b0, 3'd5, '0);
    applyStimulus(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("raw_lat1_vld", rspVld, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("raw_lat2", {rspVld, rspRdata}, {1'b1, 32'h1234_5678});
    nextCycle();

    // Distinct data everywhere, then read back in order.
    for (int k = 0; k < 8; k++) sendReq(1'b1, AW'(k), 32'h1000_0000 + 32'(k) * 32'h11);
    applyStimulus(1'b0, 1'b0, '0, '0);
    nextCycle();
    backToBackReads("b2b");

    // Back-pressure: two reads fit, then a single pop admits exactly one more.
    rspRdy = 1'b0;
    applyStimulus(1'b1, 1'b0, 3'd1, '0); @(negedge clk); checkOutput("bp_c0_rdy", reqRdy, 1); nextCycle();
    applyStimulus(1'b1, 1'b0, 3'd2, '0); @(negedge clk); checkOutput("bp_c1_rdy", reqRdy, 1); nextCycle();
    applyStimulus(1'b1, 1'b0, 3'd3, '0); @(negedge clk);
    checkOutput("bp_c2", {reqRdy, rspVld}, 2'b01); nextCycle();
    @(negedge clk); checkOutput("bp_c3_rdy", reqRdy, 0); nextCycle();
    rspRdy = 1'b1;
    @(negedge clk); checkOutput("bp_c4", {reqRdy, rspRdata}, {1'b1, 32'h1000_0011}); nextCycle();
    rspRdy = 1'b0;
    applyStimulus(1'b1, 1'b0, 3'd4, '0); @(negedge clk); checkOutput("bp_c5_rdy", reqRdy, 0); nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0);

    // Reset while the FIFO holds data drops it immediately.
    @(negedge clk);
    checkOutput("pre_reset_vld", rspVld, 1);
    #1 rstB = 1'b0;
    #1 checkOutput("run_reset", {rspVld, rspRdata, reqRdy, initDone, ramWen}, '0);
    expQ.delete();
    repeat (2) @(posedge clk);
    #1 rstB = 1'b1;

    // Reset again in the middle of the sweep at counter 4.
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("partial_sweep", {ramWen, ramAddr}, {1'b1, AW'(i)});
    end
    #1 rstB = 1'b0;
    #1 checkOutput("sweep_reset", {ramWen, ramAddr, ramDin, initDone, reqRdy, rspVld}, '0);
    nextCycle();
    rstB = 1'b1;
    sweepCheck("sweep2");

    // Address 5 was rewritten by the restarted sweep.
    rspRdy = 1'b1;
    sendReq(1'b0, 3'd5, '0);
    applyStimulus(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 20 && expQ.size() > 0; i++) nextCycle();
    checkOutput("drain_empty", expQ.size(), 0);
    checkOutput("noinit_no_writes", sawWen2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
